ni_flit_injector: RTL and testbench

Credit-based flit transmitter that drives one router input port from a node. Accepts packet descriptors from a local source and emits header, body and tail flits on a selected VC. Flits go onto that port's flit_in/flit_in_we pins. One credit counter per VC is consumed by sent flits and replenished by the router's credit_out pulses. Sits between a traffic source and a router port, on the same flit format and credit protocol the router uses.

---
 rtl/ni_flit_injector.sv | 179 +++++++++++++++++
 tb/tb_ni_flit_injector.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ni_flit_injector.sv
// ============================================================================
//  Module   : ni_flit_injector
//  Purpose  : Credit-based flit transmitter feeding one router input port.
//             Takes packet descriptors and emits header/body/tail flits on
//             the selected VC. Each VC has its own credit counter.
//  Options  : define NI_INJECTOR_STATS_EN to build the packet/flit counters
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ni_flit_injector #(
  parameter int V            = 4,
  parameter int B            = 4,
  parameter int NX           = 4,
  parameter int NY           = 4,
  parameter int Fpay         = 32,
  parameter int MAX_PCK_SIZE = 16,
  localparam int XW = $clog2(NX),
  localparam int YW = $clog2(NY),
  localparam int LW = $clog2(MAX_PCK_SIZE + 1),
  localparam int VW = (V > 1) ? $clog2(V) : 1,
  localparam int FW = 2 + V + Fpay
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [XW-1:0]     current_x,
  input  logic [YW-1:0]     current_y,
  input  logic              pck_valid,
  output logic              pck_ready,
  input  logic [XW-1:0]     pck_dest_x,
  input  logic [YW-1:0]     pck_dest_y,
  input  logic [LW-1:0]     pck_len,
  input  logic [VW-1:0]     pck_vc,
  input  logic [Fpay-1:0]   pck_data,
  output logic              data_rd,
  output logic [FW-1:0]     flit_out,
  output logic              flit_out_we,
  input  logic [V-1:0]      credit_in,
  output logic [31:0]       stat_pck_cnt,
  output logic [31:0]       stat_flit_cnt
);

  localparam int CW = $clog2(B + 1);
  localparam int HW = 2 * (XW + YW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    BODY = 2'd2
  } state_t;

  state_t          state, state_nxt;

  logic [XW-1:0]   dest_x_q, src_x_q;
  logic [YW-1:0]   dest_y_q, src_y_q;
  logic [VW-1:0]   vc_q;
  logic [LW-1:0]   remaining;
  logic [CW-1:0]   credit [V];

  logic            credit_ok;
  logic            send;
  logic            last;
  logic            accept;
  logic [LW-1:0]   len_eff;
  logic [V-1:0]    vc_oh;
  logic [V-1:0]    dec_vec;
  logic [Fpay-1:0] hdr_pay;
  logic [FW-1:0]   flit_nxt;

  // Handshake, send qualification and next-flit assembly
  always_comb begin
    credit_ok = (credit[vc_q] != '0);
    send      = ((state == HDR) || (state == BODY)) && credit_ok;
    last      = (remaining == LW'(1));
    data_rd   = (state == BODY) && credit_ok;
    // Ready is masked by reset so the source never sees a false accept
    // while the asynchronous reset holds the FSM in IDLE.
    pck_ready = (state == IDLE) && !reset;
    accept    = pck_valid && pck_ready;
    len_eff   = (pck_len == '0) ? LW'(1) : pck_len;

    vc_oh        = '0;
    vc_oh[vc_q]  = 1'b1;
    dec_vec      = '0;
    if (send) dec_vec[vc_q] = 1'b1;

    hdr_pay          = '0;
    hdr_pay[HW-1:0]  = {src_y_q, src_x_q, dest_y_q, dest_x_q};

    // The header's tail bit also follows 'last' because remaining == len
    // while in HDR, which covers single-flit packets.
    flit_nxt = {(state == HDR), last, vc_oh,
                (state == HDR) ? hdr_pay : pck_data};
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = HDR;
      HDR:     if (send)   state_nxt = last ? IDLE : BODY;
      BODY:    if (send && last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Descriptor capture on accept and remaining-flit countdown on each send
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dest_x_q  <= '0;
      dest_y_q  <= '0;
      src_x_q   <= '0;
      src_y_q   <= '0;
      vc_q      <= '0;
      remaining <= '0;
    end else if (accept) begin
      dest_x_q  <= pck_dest_x;
      dest_y_q  <= pck_dest_y;
      src_x_q   <= current_x;
      src_y_q   <= current_y;
      vc_q      <= pck_vc;
      remaining <= len_eff;
    end else if (send) begin
      remaining <= remaining - LW'(1);
    end
  end

  // Registered flit output; flit_out holds its last value while stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flit_out    <= '0;
      flit_out_we <= 1'b0;
    end else begin
      flit_out_we <= send;
      if (send) flit_out <= flit_nxt;
    end
  end

  // Per-VC credit counters: a send and a return in the same cycle cancel,
  // and returns saturate at the router buffer depth
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int v = 0; v < V; v++) credit[v] <= CW'(B);
    end else begin
      for (int v = 0; v < V; v++) begin
        if (credit_in[v] && !dec_vec[v]) begin
          if (credit[v] != CW'(B)) credit[v] <= credit[v] + CW'(1);
        end else if (!credit_in[v] && dec_vec[v]) begin
          credit[v] <= credit[v] - CW'(1);
        end
      end
    end
  end

`ifdef NI_INJECTOR_STATS_EN
  // Wrap-around packet and flit counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_pck_cnt  <= '0;
      stat_flit_cnt <= '0;
    end else if (send) begin
      stat_flit_cnt <= stat_flit_cnt + 32'd1;
      if (last) stat_pck_cnt <= stat_pck_cnt + 32'd1;
    end
  end
`else
  assign stat_pck_cnt  = '0;
  assign stat_flit_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ni_flit_injector.sv
// ============================================================================
//  Module   : tb_ni_flit_injector
//  Purpose  : Directed self-checking bench for ni_flit_injector (defaults:
//             V=4, B=4, 4x4 mesh, Fpay=32, MAX_PCK_SIZE=16)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ni_flit_injector;

  logic        clk;
  logic        reset;
  logic [1:0]  current_x, current_y;
  logic        pck_valid;
  logic        pck_ready;
  logic [1:0]  pck_dest_x, pck_dest_y;
  logic [4:0]  pck_len;
  logic [1:0]  pck_vc;
  logic [31:0] pck_data;
  logic        data_rd;
  logic [37:0] flit_out;
  logic        flit_out_we;
  logic [3:0]  credit_in;
  logic [31:0] stat_pck_cnt, stat_flit_cnt;

  int vectors;
  int miscompares;

  ni_flit_injector dut (
    .clk          (clk),
    .reset        (reset),
    .current_x    (current_x),
    .current_y    (current_y),
    .pck_valid    (pck_valid),
    .pck_ready    (pck_ready),
    .pck_dest_x   (pck_dest_x),
    .pck_dest_y   (pck_dest_y),
    .pck_len      (pck_len),
    .pck_vc       (pck_vc),
    .pck_data     (pck_data),
    .data_rd      (data_rd),
    .flit_out     (flit_out),
    .flit_out_we  (flit_out_we),
    .credit_in    (credit_in),
    .stat_pck_cnt (stat_pck_cnt),
    .stat_flit_cnt(stat_flit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [37:0] mk(input logic h, input logic t,
                                     input logic [3:0] oh, input logic [31:0] pay);
    return {h, t, oh, pay};
  endfunction

  // Present a descriptor and return at the falling edge after the accept edge
  task automatic accept(input logic [1:0] dx, input logic [1:0] dy,
                        input logic [4:0] len, input logic [1:0] vc);
    pck_valid  = 1'b1;
    pck_dest_x = dx;
    pck_dest_y = dy;
    pck_len    = len;
    pck_vc     = vc;
    check("ready_at_accept", pck_ready, 1);
    @(posedge clk);
    @(negedge clk);
    pck_valid = 1'b0;
  endtask

  // Send a packet and count flits until the tail, with a cycle budget
  task automatic run_pkt(input logic [4:0] len, input logic [1:0] vc);
    int n;
    bit done;
    n    = 0;
    done = 0;
    accept(2'd1, 2'd2, len, vc);
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      pck_data = 32'hC0DE_0000 + c;
      if (flit_out_we) begin
        n++;
        if (flit_out[36]) done = 1;
      end
    end
    check("pkt_tail_seen", done, 1);
    check("pkt_flit_count", n, len);
  endtask

  initial begin
    logic [31:0] exp_pck, exp_flit;
    vectors = 0; miscompares = 0;
    reset = 1'b1; current_x = 2'd0; current_y = 2'd0;
    pck_valid = 1'b0; pck_dest_x = '0; pck_dest_y = '0; pck_len = '0;
    pck_vc = '0; pck_data = '0; credit_in = '0;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    check("rst_ready", pck_ready, 0);
    check("rst_we", flit_out_we, 0);
    check("rst_flit", flit_out, 0);
    check("rst_data_rd", data_rd, 0);
    check("rst_stat_pck", stat_pck_cnt, 0);
    check("rst_stat_flit", stat_flit_cnt, 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_ready", pck_ready, 1);
    check("rst_credit0", dut.credit[0], 4);
    check("rst_credit3", dut.credit[3], 4);

    // ---- single-flit packet, vc2: dest_x=1, dest_y=3 from (0,0) -> payload 0x0D ----
    accept(2'd1, 2'd3, 5'd1, 2'd2);
    check("t1_no_flit_yet", flit_out_we, 0);
    @(negedge clk);
    check("t1_we", flit_out_we, 1);
    check("t1_flit", flit_out, mk(1, 1, 4'b0100, 32'h0000_000D));
    check("t1_credit2", dut.credit[2], 3);
    check("t1_ready_back", pck_ready, 1);
    @(negedge clk);
    check("t1_we_one_cycle", flit_out_we, 0);

    // ---- len=0 from (2,1) to (2,2) on vc1 -> payload 0x6A, single flit ----
    current_x = 2'd2; current_y = 2'd1;
    accept(2'd2, 2'd2, 5'd0, 2'd1);
    @(negedge clk);
    check("t4_flit", flit_out, mk(1, 1, 4'b0010, 32'h0000_006A));
    check("t4_we", flit_out_we, 1);
    check("t4_ready", pck_ready, 1);
    check("t4_credit1", dut.credit[1], 3);
    @(negedge clk);
    check("t4_we_low", flit_out_we, 0);

    // ---- 5-flit packet on vc0 to (3,0): header payload 0x63, stall after 4 ----
    accept(2'd3, 2'd0, 5'd5, 2'd0);
    check("t2_rd_in_hdr", data_rd, 0);
    @(negedge clk);
    check("t2_hdr", flit_out, mk(1, 0, 4'b0001, 32'h0000_0063));
    check("t2_rd1", data_rd, 1);
    pck_data = 32'hD000_0001;
    @(negedge clk);
    check("t2_body1", flit_out, mk(0, 0, 4'b0001, 32'hD000_0001));
    pck_data = 32'hD000_0002;
    @(negedge clk);
    check("t2_body2", flit_out, mk(0, 0, 4'b0001, 32'hD000_0002));
    check("t2_we2", flit_out_we, 1);
    pck_data = 32'hD000_0003;
    @(negedge clk);
    check("t2_body3", flit_out, mk(0, 0, 4'b0001, 32'hD000_0003));
    check("t2_rd_stall", data_rd, 0);
    check("t2_credit0_empty", dut.credit[0], 0);
    @(negedge clk);
    check("t2_we_stall", flit_out_we, 0);
    check("t2_rd_stall2", data_rd, 0);
    check("t2_flit_hold", flit_out, mk(0, 0, 4'b0001, 32'hD000_0003));
    credit_in = 4'b0001;
    pck_data  = 32'hD000_0004;
    @(negedge clk);
    credit_in = 4'b0000;
    check("t2_credit_back", dut.credit[0], 1);
    check("t2_rd_resume", data_rd, 1);
    check("t2_we_still_low", flit_out_we, 0);
    @(negedge clk);
    check("t2_tail", flit_out, mk(0, 1, 4'b0001, 32'hD000_0004));
    check("t2_tail_we", flit_out_we, 1);
    check("t2_ready_after", pck_ready, 1);

    // ---- send and credit return on the same VC in the same cycle ----
    credit_in = 4'b0001;
    repeat (2) @(negedge clk);
    credit_in = 4'b0000;
    check("t3_credit_pre", dut.credit[0], 2);
    accept(2'd1, 2'd1, 5'd2, 2'd0);
    credit_in = 4'b0001;
    @(negedge clk);
    credit_in = 4'b0000;
    check("t3_hdr", flit_out, mk(1, 0, 4'b0001, 32'h0000_0065));
    check("t3_credit_same", dut.credit[0], 2);
    pck_data = 32'hD000_0005;
    @(negedge clk);
    check("t3_tail", flit_out, mk(0, 1, 4'b0001, 32'hD000_0005));
    check("t3_credit_dec", dut.credit[0], 1);

    // ---- returns on all VCs: increments elsewhere, saturation at B on vc3 ----
    credit_in = 4'b1111;
    @(negedge clk);
    credit_in = 4'b0000;
    check("t3_credit0_inc", dut.credit[0], 2);
    check("t3_credit1_inc", dut.credit[1], 4);
    check("t3_credit2_inc", dut.credit[2], 4);
    check("t3_credit3_sat", dut.credit[3], 4);

    // ---- asynchronous reset in the middle of an 8-flit packet on vc1 ----
    accept(2'd0, 2'd1, 5'd8, 2'd1);
    @(negedge clk);
    pck_data = 32'hD000_0006;
    @(negedge clk);
    check("t5_body_active", flit_out_we, 1);
    #1 reset = 1'b1;
    #1;
    check("t5_we_clear", flit_out_we, 0);
    check("t5_rd_clear", data_rd, 0);
    check("t5_ready_low", pck_ready, 0);
    check("t5_credit0", dut.credit[0], 4);
    check("t5_credit1", dut.credit[1], 4);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("t5_idle_ready", pck_ready, 1);
    accept(2'd0, 2'd3, 5'd1, 2'd3);
    @(negedge clk);
    check("t5_new_hdr", flit_out, mk(1, 1, 4'b1000, 32'h0000_006C));

    // ---- statistics: lengths 1, 3, 2 after a fresh reset ----
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_pkt(5'd1, 2'd0);
    run_pkt(5'd3, 2'd1);
    run_pkt(5'd2, 2'd2);
`ifdef NI_INJECTOR_STATS_EN
    exp_pck = 32'd3; exp_flit = 32'd6;
`else
    exp_pck = 32'd0; exp_flit = 32'd0;
`endif
    check("stat_pck", stat_pck_cnt, exp_pck);
    check("stat_flit", stat_flit_cnt, exp_flit);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
